// File: rtl/trace_player.sv
// rtl/trace_player.sv - replays an R/W op trace table into a cache over valid/ready
// Optional hit/miss statistics: define TRACE_PLAYER_STATS_EN.
module trace_player #(
  parameter int SIZE  = 1000,
  parameter int IDX_W = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [IDX_W-1:0] op_idx,
  input  logic [7:0]       op_byte,
  output logic             req_valid,
  output logic             req_we,
  input  logic             req_ready,
  input  logic             rsp_valid,
  input  logic             rsp_hit,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count,
`ifdef TRACE_PLAYER_STATS_EN
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
`endif
  output logic [CNT_W-1:0] err_count
);

  localparam logic [7:0]       OP_R     = 8'h52;
  localparam logic [7:0]       OP_W     = 8'h57;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, FINISH} state_t;

  state_t state, state_nxt;
  logic   is_rd, is_wr, last, advance;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign is_rd = (op_byte == OP_R);
  assign is_wr = (op_byte == OP_W);
  assign last  = (op_idx == LAST_IDX);

`ifndef TRACE_PLAYER_STATS_EN
  logic unused_rsp_hit;
  assign unused_rsp_hit = rsp_hit;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // advance is shared by illegal-byte skips in FETCH and completed responses in WAIT
  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    req_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        if (is_rd || is_wr) state_nxt = ISSUE;
        else                advance   = 1'b1;
      end
      ISSUE: begin
        req_valid = 1'b1;
        if (req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (rsp_valid) advance = 1'b1;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (advance) state_nxt = last ? FINISH : FETCH;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_idx     <= '0;
      req_we     <= 1'b0;
      rd_count   <= '0;
      wr_count   <= '0;
      err_count  <= '0;
`ifdef TRACE_PLAYER_STATS_EN
      hit_count  <= '0;
      miss_count <= '0;
`endif
    end else begin
      if (state == IDLE && start) begin
        op_idx     <= '0;
        rd_count   <= '0;
        wr_count   <= '0;
        err_count  <= '0;
`ifdef TRACE_PLAYER_STATS_EN
        hit_count  <= '0;
        miss_count <= '0;
`endif
      end
      if (state == FETCH) begin
        if (is_wr)      req_we    <= 1'b1;
        else if (is_rd) req_we    <= 1'b0;
        else            err_count <= sat_inc(err_count);
      end
      if (state == ISSUE && req_ready) begin
        if (req_we) wr_count <= sat_inc(wr_count);
        else        rd_count <= sat_inc(rd_count);
      end
`ifdef TRACE_PLAYER_STATS_EN
      if (state == WAIT && rsp_valid) begin
        if (rsp_hit) hit_count  <= sat_inc(hit_count);
        else         miss_count <= sat_inc(miss_count);
      end
`endif
      if (advance && !last) op_idx <= op_idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_trace_player.sv
// tb/tb_trace_player.sv - scoreboard bench for trace_player (SIZE=4 main, SIZE=6/CNT_W=2 saturation)
// Hit/miss checks are compiled in when TRACE_PLAYER_STATS_EN is defined.
module tb_trace_player;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, req_ready, rsp_valid, rsp_hit;
  logic [9:0]  op_idx;
  logic [7:0]  op_byte;
  logic        req_valid, req_we, busy, done;
  logic [15:0] rd_count, wr_count, err_count;
`ifdef TRACE_PLAYER_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif
  logic [7:0]  tbl [0:3];

  logic        start2, req_ready2, rsp_valid2, rsp_hit2;
  logic [2:0]  op_idx2;
  logic [7:0]  op_byte2;
  logic        req_valid2, req_we2, busy2, done2;
  logic [1:0]  rd2, wr2, err2;
`ifdef TRACE_PLAYER_STATS_EN
  logic [1:0]  hit2, miss2;
`endif

  assign op_byte  = (op_idx < 10'd4) ? tbl[op_idx[1:0]] : 8'h00;
  assign op_byte2 = (op_idx2 < 3'd6) ? 8'h52 : 8'h00;

  trace_player #(.SIZE(4), .IDX_W(10), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_idx(op_idx), .op_byte(op_byte),
    .req_valid(req_valid), .req_we(req_we), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .busy(busy), .done(done),
    .rd_count(rd_count), .wr_count(wr_count),
`ifdef TRACE_PLAYER_STATS_EN
    .hit_count(hit_count), .miss_count(miss_count),
`endif
    .err_count(err_count)
  );

  trace_player #(.SIZE(6), .IDX_W(3), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .op_idx(op_idx2), .op_byte(op_byte2),
    .req_valid(req_valid2), .req_we(req_we2), .req_ready(req_ready2),
    .rsp_valid(rsp_valid2), .rsp_hit(rsp_hit2), .busy(busy2), .done(done2),
    .rd_count(rd2), .wr_count(wr2),
`ifdef TRACE_PLAYER_STATS_EN
    .hit_count(hit2), .miss_count(miss2),
`endif
    .err_count(err2)
  );

  int   total = 0;
  int   bad   = 0;
  logic exp_we_q [$];
  logic hit_q [$];
  int   stall_cnt = 0;
  bit   inj = 0;
  bit   pend = 0;
  bit   pend2 = 0;
  int   n_req = 0;
  int   e_rd, e_wr, e_err, e_hit, e_miss;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Cache model: accepts after an optional stall, responds the cycle after acceptance
  initial begin
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_hit = 1'b0;
    forever begin
      @(negedge clk);
      req_ready = 1'b0; rsp_valid = 1'b0; rsp_hit = 1'b0;
      if (pend) begin
        rsp_valid = 1'b1;
        rsp_hit   = (hit_q.size() > 0) ? hit_q.pop_front() : 1'b0;
        pend      = 0;
      end
      if (req_valid && rst_n) begin
        if (stall_cnt > 0) begin
          stall_cnt--;
          if (inj) rsp_valid = 1'b1;
          if (exp_we_q.size() > 0) check("stall_we", int'(req_we), int'(exp_we_q[0]));
        end else begin
          req_ready = 1'b1;
          pend      = 1;
          n_req++;
          if (exp_we_q.size() > 0) check("req_we", int'(req_we), int'(exp_we_q.pop_front()));
        end
      end
    end
  end

  initial begin
    req_ready2 = 1'b1; rsp_hit2 = 1'b1; rsp_valid2 = 1'b0;
    forever begin
      @(negedge clk);
      rsp_valid2 = pend2;
      pend2      = req_valid2;
    end
  end

  task automatic load(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input logic [7:0] b3, input logic [3:0] hits);
    logic [7:0] b [4];
    b = '{b0, b1, b2, b3};
    exp_we_q.delete(); hit_q.delete();
    pend = 0; n_req = 0;
    e_rd = 0; e_wr = 0; e_err = 0; e_hit = 0; e_miss = 0;
    for (int i = 0; i < 4; i++) begin
      tbl[i] = b[i];
      if (b[i] == 8'h52 || b[i] == 8'h57) begin
        exp_we_q.push_back(b[i] == 8'h57);
        hit_q.push_back(hits[i]);
        if (b[i] == 8'h57) e_wr++; else e_rd++;
        if (hits[i]) e_hit++; else e_miss++;
      end else begin
        e_err++;
      end
    end
  endtask

  task automatic wait_done(inout int cyc);
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", int'(done), 1);
  endtask

  task automatic check_end(input string tag, input int cyc, input int e_cyc);
    check({tag, "_lat"}, cyc, e_cyc);
    check({tag, "_busy_at_done"}, int'(busy), 1);
    check({tag, "_rd"}, int'(rd_count), e_rd);
    check({tag, "_wr"}, int'(wr_count), e_wr);
    check({tag, "_err"}, int'(err_count), e_err);
`ifdef TRACE_PLAYER_STATS_EN
    check({tag, "_hit"}, int'(hit_count), e_hit);
    check({tag, "_miss"}, int'(miss_count), e_miss);
`endif
    check({tag, "_nreq"}, n_req, e_rd + e_wr);
    check({tag, "_sb_left"}, exp_we_q.size(), 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, int'(done), 0);
    check({tag, "_busy_after"}, int'(busy), 0);
    check({tag, "_idx_hold"}, int'(op_idx), 3);
    check({tag, "_rd_hold"}, int'(rd_count), e_rd);
  endtask

  initial begin
    int cyc;
    int seen;
    rst_n = 1'b0; start = 1'b1; start2 = 1'b0;
    tbl = '{8'h52, 8'h52, 8'h52, 8'h52};
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_valid", int'(req_valid), 0);
    check("rst_we", int'(req_we), 0);
    check("rst_idx", int'(op_idx), 0);
    check("rst_cnts", int'(rd_count) + int'(wr_count) + int'(err_count), 0);
    rst_n = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_hold", int'(busy), 0);

    load(8'h52, 8'h57, 8'h52, 8'h57, 4'b0101);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    wait_done(cyc);
    check_end("basic", cyc, 13);

    load(8'h52, 8'h57, 8'h52, 8'h57, 4'b0011);
    stall_cnt = 5; inj = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); cyc++;
      start = 1'b1;
      check("bp_valid", int'(req_valid), 1);
      check("bp_rd", int'(rd_count), 0);
      check("bp_idx", int'(op_idx), 0);
    end
    @(negedge clk); cyc++;
    start = 1'b0; inj = 0;
    check("bp_accept_rd", int'(rd_count), 0);
    wait_done(cyc);
    check_end("bp", cyc, 18);

    load(8'h52, 8'h00, 8'h57, 8'hFF, 4'b0001);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    wait_done(cyc);
    check_end("illegal", cyc, 9);

    load(8'h52, 8'h57, 8'h52, 8'h57, 4'b1111);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 0;
    while (rd_count != 16'd1 && cyc < 50) begin @(negedge clk); cyc++; end
    check("abort_reach_wait", int'(rd_count), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_idx", int'(op_idx), 0);
    check("abort_rd", int'(rd_count), 0);
    check("abort_valid", int'(req_valid), 0);
    rst_n = 1'b1; seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    check("abort_no_done", seen, 0);

    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0; cyc = 1;
    while (!done2 && cyc < 200) begin @(negedge clk); cyc++; end
    check("sat_done", int'(done2), 1);
    check("sat_lat", cyc, 19);
    check("sat_rd", int'(rd2), 3);
    check("sat_wr", int'(wr2), 0);
    check("sat_err", int'(err2), 0);
`ifdef TRACE_PLAYER_STATS_EN
    check("sat_hit", int'(hit2), 3);
    check("sat_miss", int'(miss2), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/trace_player.md
# trace_player

Sequencer that replays a stored memory-operation trace into the cache under test. It walks a trace op table of ASCII op bytes ('R' = 8'h52 read, 'W' = 8'h57 write) by index and decodes each byte. It then issues one request per op to the cache over a valid/ready handshake and waits for the cache response. Sits between the trace op table (read side) and the cache request port; keeps per-run read/write/error counts and, optionally, hit/miss statistics.

## Interface

Parameters:
- SIZE, 1000: number of op entries in the trace table.
- IDX_W, 10: width of op index; must satisfy 2^IDX_W >= SIZE.
- CNT_W, 16: width of every statistics counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- op_idx  out  IDX_W  registered index into trace table.
- op_byte  in  8  table entry at op_idx; combinational from table, valid same cycle.
- req_valid  out  1  request to cache.
- req_we  out  1  1 = write, 0 = read; meaningful while req_valid.
- req_ready  in  1  cache accepts request.
- rsp_valid  in  1  cache completed the outstanding request.
- rsp_hit  in  1  hit flag, qualified by rsp_valid.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at end of run.
- rd_count, wr_count, err_count  out  CNT_W each  reads issued, writes issued, illegal bytes skipped.
- hit_count, miss_count  out  CNT_W each  present only with TRACE_PLAYER_STATS_EN.

## Operation

- FSM states: IDLE, FETCH, ISSUE, WAIT, FINISH.
- IDLE: start=1 → op_idx=0, all counters cleared, go FETCH. Otherwise hold.
- FETCH: decode op_byte.
  - 8'h52 → req_we=0, go ISSUE.
  - 8'h57 → req_we=1, go ISSUE.
  - Any other value → err_count+1, advance (see below); no request issued.
- ISSUE: req_valid=1; req_we held stable until handshake. req_valid & req_ready → rd_count or wr_count +1, go WAIT.
- WAIT: req_valid=0. rsp_valid=1 → hit_count or miss_count +1 per rsp_hit, then advance. rsp_valid outside WAIT is ignored.
- Advance: if op_idx == SIZE-1, go FINISH; else op_idx+1 and go FETCH.
- FINISH: done=1 for exactly one cycle, then IDLE. op_idx and counters hold their final values until the next start.
- start while busy: ignored.
- Counters saturate at all-ones; no wrap.
- Only one request outstanding at any time.

## Timing

- Reset (rst_n=0 at clk edge): state=IDLE, op_idx=0, req_valid=0, req_we=0, busy=0, done=0, all counters 0. Reset mid-run aborts immediately with no done pulse.
- start→first req_valid: 2 cycles (IDLE→FETCH→ISSUE).
- Minimum per valid op: 3 cycles (FETCH, ISSUE with req_ready=1, WAIT with rsp_valid=1).
- Illegal byte: 1 cycle (FETCH only).
- rsp_valid asserted in the same cycle as the accepting handshake is not observed. The responder returns rsp_valid no earlier than the cycle after acceptance.
- done rises the cycle after the last op's response; busy falls together with done.

## Configuration

- TRACE_PLAYER_STATS_EN defined: hit_count/miss_count ports and counters exist, updated in WAIT per rsp_hit.
- Undefined: those ports and registers are absent. rsp_hit is an unused input. WAIT only waits for rsp_valid; all other behaviour is identical.

## Test plan

- Reset: hold rst_n=0 with start=1 → all outputs 0, busy=0; release → stays IDLE until start.
- SIZE=4, table R,W,R,W, req_ready=1, rsp_valid the cycle after acceptance, rsp_hit=1,0,1,0 → 4 requests with req_we=0,1,0,1; rd_count=2, wr_count=2; hit=2, miss=2 (STATS); done at cycle 13 after start; busy falls with it.
- Backpressure: req_ready low 5 cycles on op 0 → req_valid and req_we stable throughout; rd_count increments only at the handshake.
- Illegal bytes: table 8'h52,8'h00,8'h57,8'hFF → err_count=2, rd_count=1, wr_count=1, exactly 2 requests issued.
- start pulsed mid-run and rsp_valid pulsed in ISSUE → no restart, no counter change; rst_n=0 in WAIT → IDLE next cycle, no done pulse.
- Saturation with CNT_W=2, SIZE=6, all 'R' → rd_count=3 (saturated) at done.
